sub8_serial: RTL and testbench

Bit-serial 8-bit two's-complement subtractor with borrow-in/borrow-out: computes Diff = A − B − Bin one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It sits beside the ripple adder in the 8-bit ALU as the area-minimal subtract path. A Start/Busy/Done handshake lets the ALU controller issue operations and collect results.

---
 rtl/sub8_serial.sv | 163 ++++++++++++++++
 tb/tb_sub8_serial.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sub8_serial.sv
// Bit-serial 8-bit subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// One full-subtractor cell plus a borrow flop; Start/Busy/Done handshake.
// Optional macro SUB8_SERIAL_FLAGS_EN enables the V (signed overflow) and
// Z (zero) flags; without it both read as 0 and their logic is absent.
module sub8_serial (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Bin,
    output logic [7:0] Diff,
    output logic       Bout,
    output logic       V,
    output logic       Z,
    output logic       Busy,
    output logic       Done
);

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic            br_q, br_d;
    logic [W-1:0]    diff_q, diff_d;
    logic            bout_q, bout_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef SUB8_SERIAL_FLAGS_EN
    logic            v_q, v_d;
    logic            z_q, z_d;
`endif

    // Full-subtractor cell on the current LSBs and the borrow flop
    logic         d_bit_c;
    logic         br_nxt_c;
    logic [W-1:0] res_nxt_c;

    assign d_bit_c   = a_q[0] ^ b_q[0] ^ br_q;
    assign br_nxt_c  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign res_nxt_c = {d_bit_c, res_q[W-1:1]};

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef SUB8_SERIAL_FLAGS_EN
        v_d     = v_q;
        z_d     = z_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_SHIFT;
                    busy_d  = 1'b1;
                    a_d     = A;
                    b_d     = B;
                    br_d    = Bin;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                res_d  = res_nxt_c;
                br_d   = br_nxt_c;
                cnt_d  = CW'(cnt_q + CW'(1));
                busy_d = 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    diff_d  = res_nxt_c;
                    bout_d  = br_nxt_c;
`ifdef SUB8_SERIAL_FLAGS_EN
                    v_d     = br_q ^ br_nxt_c;
                    z_d     = (res_nxt_c == '0);
`endif
                end
            end
            ST_DONE: begin
                // Start here chains straight into the next operation
                if (Start) begin
                    state_d = ST_SHIFT;
                    busy_d  = 1'b1;
                    a_d     = A;
                    b_d     = B;
                    br_d    = Bin;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SUB8_SERIAL_FLAGS_EN
            v_q     <= 1'b0;
            z_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SUB8_SERIAL_FLAGS_EN
            v_q     <= v_d;
            z_q     <= z_d;
`endif
        end
    end

    assign Diff = diff_q;
    assign Bout = bout_q;
    assign Busy = busy_q;
    assign Done = done_q;
`ifdef SUB8_SERIAL_FLAGS_EN
    assign V    = v_q;
    assign Z    = z_q;
`else
    assign V    = 1'b0;
    assign Z    = 1'b0;
`endif

endmodule

// File: tb/tb_sub8_serial.sv
// Scoreboard bench for sub8_serial: stimulus pushes expected results computed
// arithmetically; a negedge monitor checks handshake timing and held outputs.
module tb_sub8_serial;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       Bin = 1'b0;
    logic [7:0] Diff;
    logic       Bout, V, Z, Busy, Done;

    sub8_serial dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B), .Bin(Bin),
        .Diff(Diff), .Bout(Bout), .V(V), .Z(Z), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] diff;
        logic       bout;
        logic       v;
        logic       z;
        int         due;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;
    logic [7:0] last_diff = '0;
    logic       last_bout = 1'b0;
    logic       last_v = 1'b0;
    logic       last_z = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic on the operands
    function automatic exp_t model(logic [7:0] a, logic [7:0] b, logic bin, int due);
        exp_t m;
        int u;
        int s;
        u = int'(a) - int'(b) - int'(bin);
        s = int'($signed(a)) - int'($signed(b)) - int'(bin);
        m.diff = 8'(u);
        m.bout = (u < 0);
`ifdef SUB8_SERIAL_FLAGS_EN
        m.v = (s < -128) || (s > 127);
        m.z = (m.diff == 8'h00);
`else
        m.v = 1'b0;
        m.z = 1'b0;
`endif
        m.due = due;
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: Done exactly 8 edges after the accepting edge, Busy in between,
    // result outputs held at the last completed values otherwise
    always @(negedge Clk) begin
        if (mon_en) begin
            if (q.size() > 0 && cyc >= q[0].due) begin
                chk("done_pulse", 32'(Done), 32'd1);
                chk("busy_in_done", 32'(Busy), 32'd0);
                chk("diff", 32'(Diff), 32'(q[0].diff));
                chk("bout", 32'(Bout), 32'(q[0].bout));
                chk("v", 32'(V), 32'(q[0].v));
                chk("z", 32'(Z), 32'(q[0].z));
                last_diff = q[0].diff;
                last_bout = q[0].bout;
                last_v    = q[0].v;
                last_z    = q[0].z;
                void'(q.pop_front());
            end else begin
                chk("busy", 32'(Busy), (q.size() > 0) ? 32'd1 : 32'd0);
                chk("no_done", 32'(Done), 32'd0);
                chk("held_outputs", {21'(0), Diff, Bout, V, Z}, {21'(0), last_diff, last_bout, last_v, last_z});
            end
        end
    end

    // Drive Start for one edge; caller guarantees the DUT is IDLE or DONE
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bin);
        Start = 1'b1;
        A = a;
        B = b;
        Bin = bin;
        @(posedge Clk);
        #1;
        q.push_back(model(a, b, bin, cyc + 8));
        Start = 1'b0;
    endtask

    // Returns just after the negedge on which the pending result was checked
    task automatic wait_done();
        int i;
        for (i = 0; i < 30; i++) begin
            if (q.size() == 0) break;
            @(negedge Clk);
            #1;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout at cycle %0d: got no Done, expected Done within 30 cycles", cyc);
            q.delete();
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        q.delete();
        last_diff = '0;
        last_bout = 1'b0;
        last_v = 1'b0;
        last_z = 1'b0;
        Reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        mon_en = 1'b1;

        // Directed cases from the plan
        start_op(8'h05, 8'h03, 1'b0); wait_done();
        @(posedge Clk); #1;
        start_op(8'h03, 8'h05, 1'b0); wait_done();
        @(posedge Clk); #1;
        start_op(8'h80, 8'h01, 1'b0); wait_done();
        @(posedge Clk); #1;
        start_op(8'h10, 8'h0F, 1'b1); wait_done();
        start_op(8'hFF, 8'h00, 1'b0); wait_done();
        @(posedge Clk); #1;

        // Start during SHIFT is ignored
        start_op(8'h55, 8'h23, 1'b0);
        repeat (2) @(posedge Clk);
        #1;
        Start = 1'b1; A = 8'h11; B = 8'h99; Bin = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        wait_done();
        repeat (3) @(posedge Clk);
        #1;

        // Reset at E4 discards the operation
        start_op(8'hA7, 8'h3C, 1'b1);
        repeat (3) @(posedge Clk);
        #1;
        do_reset();
        @(posedge Clk); #1;
        start_op(8'h05, 8'h03, 1'b0); wait_done();
        @(posedge Clk); #1;

        // Reset wins over Start in the same cycle
        Start = 1'b1; A = 8'h42; B = 8'h01; Bin = 1'b0;
        do_reset();
        Start = 1'b0;
        repeat (2) @(posedge Clk);
        #1;

        // Randomized operations with random gaps or back-to-back chaining
        for (int n = 0; n < 150; n++) begin
            logic [7:0] ra, rb;
            logic       rbin;
            int         gap;
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) rb = ra;
            if ($urandom_range(0, 7) == 0) ra = 8'h80;
            start_op(ra, rb, rbin);
            wait_done();
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                repeat (gap) @(posedge Clk);
                #1;
            end
        end

        repeat (4) @(posedge Clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
